// File: rtl/isect_pkg.sv
// Shared types and constants for the ray/triangle sweep sequencer.
package isect_pkg;

    typedef logic [0:2][31:0]       vec3_t;
    typedef logic [0:2][0:2][31:0]  triangle_t;
    typedef logic [0:1][0:2][31:0]  ray_t;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StEval,
        StDone
    } sweep_state_t;

    localparam logic signed [31:0] Q16_ONE = 32'sh00010000;

endpackage

// File: rtl/isect_best_hit.sv
// Closest-hit tracker: keeps best t / index / normal plus the sticky invalid flag.
module isect_best_hit #(
    parameter int unsigned IDX_W = 16
) (
    input  logic             i_clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_sample,
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_result,
    input  logic             i_invalid,
    input  logic [31:0]      i_t,
    input  logic [0:2][31:0] i_normal,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_idx,
    output logic [31:0]      o_t,
    output logic [0:2][31:0] o_normal,
    output logic             o_invalid
);

    logic take;

    // Strict less-than keeps the earlier (lower) index on equal t.
    always_comb begin
        take = i_sample && i_result && !i_invalid &&
               (!o_hit || ($signed(i_t) < $signed(o_t)));
    end

    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            o_hit     <= 1'b0;
            o_idx     <= '0;
            o_t       <= '0;
            o_normal  <= '0;
            o_invalid <= 1'b0;
        end else if (i_clear) begin
            o_hit     <= 1'b0;
            o_idx     <= '0;
            o_t       <= '0;
            o_normal  <= '0;
            o_invalid <= 1'b0;
        end else begin
            if (take) begin
                o_hit    <= 1'b1;
                o_idx    <= i_idx;
                o_t      <= i_t;
                o_normal <= i_normal;
            end
            if (i_sample && i_invalid) begin
                o_invalid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/isect_sweep_ctrl.sv
// Sweeps one ray over a contiguous triangle list, keeping the closest valid hit.
// Optional ISECT_ANY_HIT_EN adds i_any_hit: stop at the first accepted hit (shadow rays).
module isect_sweep_ctrl
    import isect_pkg::*;
#(
    parameter int unsigned IDX_W     = 16,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned ISECT_LAT = 0
) (
    input  logic                   i_clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [0:1][0:2][31:0]  i_ray,
    input  logic [ADDR_W-1:0]      i_base,
    input  logic [IDX_W-1:0]       i_count,
`ifdef ISECT_ANY_HIT_EN
    input  logic                   i_any_hit,
`endif
    output logic                   o_tri_req,
    output logic [ADDR_W-1:0]      o_tri_addr,
    input  logic                   i_tri_valid,
    input  logic [0:2][0:2][31:0]  i_tri_data,
    output logic [0:2][0:2][31:0]  o_isect_triangle,
    output logic [0:1][0:2][31:0]  o_isect_ray,
    input  logic                   i_isect_result,
    input  logic                   i_isect_invalid,
    input  logic [31:0]            i_isect_t,
    input  logic [0:2][31:0]       i_isect_normal,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_hit,
    output logic [IDX_W-1:0]       o_hit_idx,
    output logic [31:0]            o_hit_t,
    output logic [0:2][31:0]       o_hit_normal,
    output logic                   o_invalid
);

    localparam int unsigned CntW = (ISECT_LAT > 0) ? $clog2(ISECT_LAT + 1) : 1;

    sweep_state_t     state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] count_q;
    logic [CntW-1:0]  cnt_q;
    logic             clear;
    logic             sample;
    logic             last;
    logic             stop_early;

    assign o_ready   = (state_q == StIdle);
    assign o_valid   = (state_q == StDone);
    assign o_tri_req = (state_q == StFetch);

    assign clear  = (state_q == StIdle) && i_valid;
    assign sample = (state_q == StEval) && (cnt_q == '0);
    assign last   = (idx_q == count_q - IDX_W'(1));

`ifdef ISECT_ANY_HIT_EN
    logic any_hit_q;

    // In any-hit mode nothing is held before the first hit, so any clean hit is taken.
    assign stop_early = any_hit_q && i_isect_result && !i_isect_invalid;

    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            any_hit_q <= 1'b0;
        end else if (clear) begin
            any_hit_q <= i_any_hit;
        end
    end
`else
    assign stop_early = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            state_q          <= StIdle;
            idx_q            <= '0;
            count_q          <= '0;
            cnt_q            <= '0;
            o_tri_addr       <= '0;
            o_isect_triangle <= '0;
            o_isect_ray      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_valid) begin
                        o_isect_ray <= i_ray;
                        o_tri_addr  <= i_base;
                        count_q     <= i_count;
                        idx_q       <= '0;
                        state_q     <= (i_count == '0) ? StDone : StFetch;
                    end
                end
                StFetch: begin
                    if (i_tri_valid) begin
                        o_isect_triangle <= i_tri_data;
                        cnt_q            <= CntW'(ISECT_LAT);
                        state_q          <= StEval;
                    end
                end
                StEval: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CntW'(1);
                    end else if (last || stop_early) begin
                        state_q <= StDone;
                    end else begin
                        // o_tri_addr tracks base + idx and wraps at ADDR_W.
                        idx_q      <= idx_q + IDX_W'(1);
                        o_tri_addr <= o_tri_addr + ADDR_W'(1);
                        state_q    <= StFetch;
                    end
                end
                StDone: begin
                    if (i_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    isect_best_hit #(
        .IDX_W (IDX_W)
    ) u_best_hit (
        .i_clk     (i_clk),
        .rst       (rst),
        .i_clear   (clear),
        .i_sample  (sample),
        .i_idx     (idx_q),
        .i_result  (i_isect_result),
        .i_invalid (i_isect_invalid),
        .i_t       (i_isect_t),
        .i_normal  (i_isect_normal),
        .o_hit     (o_hit),
        .o_idx     (o_hit_idx),
        .o_t       (o_hit_t),
        .o_normal  (o_hit_normal),
        .o_invalid (o_invalid)
    );

endmodule
